// File: rtl/uart_pkg.sv
// Shared UART byte-path definitions: ASCII constants, byte type and a ceil-log2 helper.
package uart_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t ASCII_CR    = 8'h0D;
    localparam byte_t ASCII_LF    = 8'h0A;
    localparam byte_t ASCII_QMARK = 8'h3F;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_echo_responder_if.sv
// Byte-stream valid/ready channel with per-byte error qualifiers, as produced by uart_rx.
interface uart_echo_responder_if;

    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       parity_err;
    logic       frame_err;

    modport master (
        output valid,
        output data,
        output parity_err,
        output frame_err,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  parity_err,
        input  frame_err,
        output ready
    );

endinterface

// File: rtl/uart_byte_fifo.sv
// DEPTH x 8 show-ahead FIFO with two write ports (second write lands after the first) and one pop.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_push0,
    input  logic          i_push1,
    input  byte_t         i_data0,
    input  byte_t         i_data1,
    input  logic          i_pop,
    output byte_t         o_head,
    output logic [CW-1:0] o_count
);

    byte_t         r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] w_wr_ptr1;

    assign w_wr_ptr1 = r_wr_ptr + AW'(1);

    // i_push1 is only meaningful together with i_push0; it fills the slot after i_data0.
    always_ff @(posedge clk) begin
        if (i_push0) r_mem[r_wr_ptr]  <= i_data0;
        if (i_push1) r_mem[w_wr_ptr1] <= i_data1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(i_push0) + AW'(i_push1);
            r_rd_ptr <= r_rd_ptr + AW'(i_pop);
            r_count  <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/uart_echo_responder.sv
// Far-end echo responder: buffers uart_rx bytes, substitutes errored bytes, expands CR, re-emits to uart_tx.
module uart_echo_responder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter byte_t       ERR_CHAR   = ASCII_QMARK,
    parameter bit          CR_TO_CRLF = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 echo_en,
    uart_echo_responder_if.slave  rx,
    uart_echo_responder_if.master tx,
    output logic [CNT_W-1:0]     rx_count,
    output logic [CNT_W-1:0]     err_count,
    output logic                 overflow
);

    localparam int unsigned     CW        = clog2(DEPTH) + 1;
    localparam int unsigned     SW        = clog2(2 * DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0]   NEED_C    = CR_TO_CRLF ? CW'(2) : CW'(1);
    localparam logic [SW-1:0]   STALL_LIM = SW'(2 * DEPTH);

    logic             r_rx_ready;
    logic             r_tx_valid;
    byte_t            r_tx_data;
    logic [CNT_W-1:0] r_rx_count;
    logic [CNT_W-1:0] r_err_count;
    logic [SW-1:0]    r_stall;
    logic             r_overflow;

    logic             w_accept;
    logic             w_err;
    byte_t            w_byte;
    logic             w_push0;
    logic             w_push1;
    logic             w_load;
    byte_t            w_head;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_count_next;
    logic [CW-1:0]    w_free;
    logic [SW-1:0]    w_stall_next;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push0 (w_push0),
        .i_push1 (w_push1),
        .i_data0 (w_byte),
        .i_data1 (ASCII_LF),
        .i_pop   (w_load),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // The tx register is the output slot: it reloads from the FIFO head whenever it is empty or being consumed.
    always_comb begin
        w_accept     = rx.valid && r_rx_ready;
        w_err        = rx.parity_err || rx.frame_err;
        w_byte       = w_err ? ERR_CHAR : rx.data;
        w_push0      = w_accept && echo_en;
        w_push1      = w_push0 && CR_TO_CRLF && (w_byte == ASCII_CR);
        w_load       = (w_count != '0) && (!r_tx_valid || tx.ready);
        w_count_next = w_count + CW'(w_push0) + CW'(w_push1) - CW'(w_load);
        w_free       = DEPTH_C - w_count_next;
        w_stall_next = '0;
        if (rx.valid && !r_rx_ready)
            w_stall_next = (r_stall == STALL_LIM) ? r_stall : r_stall + SW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_ready  <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_rx_count  <= '0;
            r_err_count <= '0;
            r_stall     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_rx_ready <= (w_free >= NEED_C);
            if (w_load) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_head;
            end else if (tx.ready) begin
                r_tx_valid <= 1'b0;
            end
            r_stall <= w_stall_next;
            if (w_stall_next == STALL_LIM) r_overflow <= 1'b1;
            if (w_accept) begin
                if (r_rx_count != '1)           r_rx_count  <= r_rx_count + CNT_W'(1);
                if (w_err && r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    assign rx.ready      = r_rx_ready;
    assign tx.valid      = r_tx_valid;
    assign tx.data       = r_tx_data;
    assign tx.parity_err = 1'b0;
    assign tx.frame_err  = 1'b0;
    assign rx_count      = r_rx_count;
    assign err_count     = r_err_count;
    assign overflow      = r_overflow;

endmodule
